// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: word width and the RAM handshake state seen by the arbiter.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between the instruction and data request paths.
// Data wins over instruction; a watchdog counter and RAM errors latch a sticky memerr.
//
//   state | meaning
//   IDLE  | no access in flight; also the turnaround cycle after every hit
//   DATA  | serving the data request (write wins over read)
//   INSTR | serving the instruction fetch
//   ERR   | timeout or RAM error seen; parked here until reset
import cpu_types_pkg::*;

module memory_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      ihit,
    output word_t     iload,
    output logic      dhit,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      memerr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        INSTR = 2'd2,
        ERR   = 2'd3
    } arb_state_t;

    localparam logic [7:0] TMO_CNT = 8'(TIMEOUT);

    arb_state_t state;
    logic [7:0] wait_cnt;
    logic [7:0] wait_inc;
    logic       req_active;

    assign wait_inc   = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
    assign req_active = (state == DATA) ? (dREN | dWEN) : iREN;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
            memerr   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    wait_cnt <= 8'd0;
                    if (dREN | dWEN)
                        state <= DATA;
                    else if (iREN)
                        state <= INSTR;
                end
                DATA, INSTR: begin
                    if (ramstate != ACCESS)
                        wait_cnt <= wait_inc;
                    // A hard RAM error outranks an abort; a timeout only applies to a live request
                    if (ramstate == ERROR) begin
                        state  <= ERR;
                        memerr <= 1'b1;
                    end else if (!req_active || ramstate == ACCESS) begin
                        state <= IDLE;
                    end else if (wait_inc >= TMO_CNT) begin
                        state  <= ERR;
                        memerr <= 1'b1;
                    end
                end
                ERR: begin
                    memerr <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        ihit     = 1'b0;
        dhit     = 1'b0;
        iload    = '0;
        dload    = '0;
        unique case (state)
            DATA: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dhit     = (ramstate == ACCESS) && (dREN | dWEN);
                dload    = (dhit && dREN) ? ramload : '0;
            end
            INSTR: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                ihit    = (ramstate == ACCESS) && iREN;
                iload   = ihit ? ramload : '0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: stimulus pushes expected hits, a negedge monitor pops and checks.
import cpu_types_pkg::*;

module tb_memory_arbiter;

    localparam int TMO = 4;

    logic      CLK = 1'b0;
    logic      RST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore, ramload;
    ramstate_t ramstate;
    logic      ihit, dhit, ramREN, ramWEN, memerr;
    word_t     iload, dload, ramaddr, ramstore;

    always #5 CLK = ~CLK;

    memory_arbiter #(.TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
    );

    typedef struct packed {
        logic  is_instr;
        word_t load;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_ram(input string name, input logic ren, input logic wen,
                             input word_t addr, input word_t store);
        check({name, "_ramREN"}, 32'(ramREN), 32'(ren));
        check({name, "_ramWEN"}, 32'(ramWEN), 32'(wen));
        check({name, "_ramaddr"}, ramaddr, addr);
        check({name, "_ramstore"}, ramstore, store);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every hit must match the oldest expected response
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (ihit || dhit) begin
                check("hit_exclusive", 32'(ihit & dhit), 32'd0);
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_hit: ihit=%0b dhit=%0b, expected no hit", ihit, dhit);
                end else begin
                    e = sb_q.pop_front();
                    check("hit_kind_ihit", 32'(ihit), 32'(e.is_instr));
                    check("hit_kind_dhit", 32'(dhit), 32'(!e.is_instr));
                    if (e.is_instr) begin
                        check("iload", iload, e.load);
                        check("dload_idle", dload, 32'd0);
                    end else begin
                        check("dload", dload, e.load);
                        check("iload_idle", iload, 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
        ramstate = FREE;

        // Reset state, before any clock edge
        #1;
        check_ram("reset", 1'b0, 1'b0, 32'd0, 32'd0);
        check("reset_ihit", 32'(ihit), 32'd0);
        check("reset_dhit", 32'(dhit), 32'd0);
        check("reset_memerr", 32'(memerr), 32'd0);
        check("reset_dload", dload, 32'd0);
        check("reset_iload", iload, 32'd0);
        tick();
        tick();
        RST = 1'b0;
        tick();

        // Data read, ACCESS on third cycle
        dREN = 1'b1; daddr = 32'h40; ramstate = BUSY;
        tick();
        check_ram("rd_c1", 1'b1, 1'b0, 32'h40, 32'h0);
        tick();
        check_ram("rd_c2", 1'b1, 1'b0, 32'h40, 32'h0);
        ramstate = ACCESS; ramload = 32'hDEADBEEF;
        sb_q.push_back('{is_instr: 1'b0, load: 32'hDEADBEEF});
        tick();
        ramstate = FREE;
        check("rd_turn_dhit", 32'(dhit), 32'd0);
        check_ram("rd_turn", 1'b0, 1'b0, 32'h0, 32'h0);
        dREN = 1'b0;
        tick();
        check_ram("rd_after", 1'b0, 1'b0, 32'h0, 32'h0);

        // Simultaneous iREN and dWEN: data write first, turnaround, then fetch
        iREN = 1'b1; iaddr = 32'h100;
        dWEN = 1'b1; daddr = 32'h80; dstore = 32'h12345678;
        ramstate = BUSY;
        tick();
        check_ram("pri_data", 1'b0, 1'b1, 32'h80, 32'h12345678);
        ramstate = ACCESS; ramload = 32'hAAAA5555;
        sb_q.push_back('{is_instr: 1'b0, load: 32'h0});
        tick();
        dWEN = 1'b0; ramstate = BUSY;
        check_ram("pri_turn", 1'b0, 1'b0, 32'h0, 32'h0);
        check("pri_turn_ihit", 32'(ihit), 32'd0);
        tick();
        check_ram("pri_instr", 1'b1, 1'b0, 32'h100, 32'h0);
        ramstate = ACCESS; ramload = 32'h0BADF00D;
        sb_q.push_back('{is_instr: 1'b1, load: 32'h0BADF00D});
        tick();
        iREN = 1'b0; ramstate = FREE;
        check_ram("pri_end", 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // dREN and dWEN both high: write wins, read word still returned
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h44; dstore = 32'h55;
        tick();
        check_ram("rw_both", 1'b0, 1'b1, 32'h44, 32'h55);
        ramstate = ACCESS; ramload = 32'h11223344;
        sb_q.push_back('{is_instr: 1'b0, load: 32'h11223344});
        tick();
        dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
        tick();

        // Instruction request dropped while BUSY: abort, no hit
        iREN = 1'b1; iaddr = 32'h300; ramstate = BUSY;
        tick();
        check_ram("abort_instr", 1'b1, 1'b0, 32'h300, 32'h0);
        tick();
        iREN = 1'b0;
        tick();
        check_ram("abort_idle", 1'b0, 1'b0, 32'h0, 32'h0);
        check("abort_ihit", 32'(ihit), 32'd0);
        ramstate = FREE;
        tick();

        // Timeout: BUSY held for TMO cycles in DATA
        dREN = 1'b1; daddr = 32'h500; ramstate = BUSY;
        tick();
        tick();
        tick();
        tick();
        check("tmo_before_memerr", 32'(memerr), 32'd0);
        check("tmo_before_ramREN", 32'(ramREN), 32'd1);
        tick();
        check("tmo_memerr", 32'(memerr), 32'd1);
        check_ram("tmo_err", 1'b0, 1'b0, 32'h0, 32'h0);
        ramstate = ACCESS; ramload = 32'hCAFEF00D;
        tick();
        tick();
        tick();
        check("err_sticky_memerr", 32'(memerr), 32'd1);
        check("err_dhit", 32'(dhit), 32'd0);
        check("err_ramREN", 32'(ramREN), 32'd0);
        #2;
        RST = 1'b1;
        #1;
        check("err_reset_memerr", 32'(memerr), 32'd0);
        dREN = 1'b0; ramstate = FREE;
        tick();
        RST = 1'b0;
        tick();

        // Reset asserted between edges during a data write
        dWEN = 1'b1; daddr = 32'h200; dstore = 32'h77; ramstate = BUSY;
        tick();
        check("mid_ramWEN_before", 32'(ramWEN), 32'd1);
        #2;
        RST = 1'b1;
        ramstate = ACCESS;
        #1;
        check_ram("mid_rst", 1'b0, 1'b0, 32'h0, 32'h0);
        check("mid_rst_dhit", 32'(dhit), 32'd0);
        check("mid_rst_memerr", 32'(memerr), 32'd0);
        tick();
        check("mid_rst_held_ramWEN", 32'(ramWEN), 32'd0);
        dWEN = 1'b0; ramstate = FREE;
        RST = 1'b0;
        tick();
        check_ram("mid_rst_idle", 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the maximum wait in cycles for a RAM access before the error flag sets.
REQ-002 SHALL have port CLK  input  1  system clock, rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports iREN input 1, iaddr input 32: instruction read request and word address.
REQ-005 SHALL have ports dREN input 1, dWEN input 1, daddr input 32, dstore input 32: data read/write request, address and write data.
REQ-006 SHALL have ports ihit output 1, iload output 32: instruction access complete and fetched word.
REQ-007 SHALL have ports dhit output 1, dload output 32: data access complete and read word.
REQ-008 SHALL have ports ramREN output 1, ramWEN output 1, ramaddr output 32, ramstore output 32 toward RAM.
REQ-009 SHALL have ports ramload input 32, ramstate input ramstate_t (FREE, BUSY, ACCESS, ERROR) from RAM.
REQ-010 SHALL have port memerr output 1: sticky timeout or RAM-error flag.

Function
REQ-011 SHALL be the responder to the request unit: it serves iREN/dREN/dWEN and returns ihit/dhit.
REQ-012 SHALL implement an FSM with states IDLE, DATA, INSTR, ERR.
REQ-013 SHALL transition from IDLE to DATA when dREN or dWEN is high, otherwise to INSTR when iREN is high, otherwise stay in IDLE; data requests have priority over instruction requests.
REQ-014 SHALL, in DATA, drive ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN and not dWEN; when dREN and dWEN are both high, the write wins.
REQ-015 SHALL, in INSTR, drive ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
REQ-016 SHALL, in IDLE and ERR, drive ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
REQ-017 SHALL assert dhit (DATA) or ihit (INSTR) combinationally for exactly the cycle in which ramstate==ACCESS, then return to IDLE on the next edge.
REQ-018 SHALL pass dload=ramload when dhit and dREN are high, and iload=ramload when ihit is high; both outputs are 0 otherwise.
REQ-019 SHALL make the IDLE cycle after every hit a mandatory turnaround, so a requester has one cycle to drop its enable and no request is double-served.
REQ-020 SHALL abort to IDLE with no hit if the active request is deasserted before ACCESS (DATA: dREN|dWEN low; INSTR: iREN low).
REQ-021 SHALL keep an 8-bit wait counter that clears on state entry, increments each cycle in DATA/INSTR without ACCESS, and saturates.
REQ-022 SHALL enter ERR and set memerr when the counter reaches TIMEOUT or ramstate==ERROR; memerr is sticky and the block never leaves ERR and never asserts a hit until reset.
REQ-023 SHALL never assert ihit and dhit in the same cycle.
REQ-024 SHALL give each access minimum latency of 1 cycle (IDLE to DATA/INSTR edge, ACCESS in the next cycle).

Reset
REQ-025 SHALL, while RST is high, set the state to IDLE, clear the counter and memerr, and hold all outputs at 0, independent of CLK.
REQ-026 SHALL, when reset is asserted mid-access, drop ramREN/ramWEN immediately and produce no hit.

Structure
REQ-027 SHALL take ramstate_t, word_t and WORD_W from cpu_types_pkg; the FSM state enum stays local to the module.
REQ-028 SHALL be a single module with one registered state/counter block and one combinational output block; no sub-module.

Verification
REQ-029 SHALL test dREN=1, daddr=0x40, RAM ACCESS on the 3rd cycle -> dhit pulses one cycle with dload=ramload=0xDEADBEEF, then IDLE.
REQ-030 SHALL test iREN and dWEN raised in the same cycle -> data write served first (ramWEN=1, ramaddr=daddr), then one IDLE cycle, then INSTR with ramaddr=iaddr.
REQ-031 SHALL test iREN dropped while ramstate==BUSY -> return to IDLE, ihit never asserted.
REQ-032 SHALL test ramstate held at BUSY for TIMEOUT=4 cycles -> memerr=1, state ERR, no hits until RST.
REQ-033 SHALL test RST asserted mid-DATA between clock edges -> ramWEN and dhit low immediately, state IDLE, memerr=0.
